// File: rtl/dmem_pkg.sv
// Shared constants and state encoding for the data-memory arbiter.
package dmem_pkg;

  localparam logic [31:0] MEM_BASE = 32'hFFFFFF00;

  localparam logic ID_CPU = 1'b0;
  localparam logic ID_LDR = 1'b1;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request, response and memory-side signals of the data-memory arbiter.
interface dmem_arbiter_if;

  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_stall;

  logic        ldr_req;
  logic        ldr_we;
  logic        ldr_lock;
  logic [31:0] ldr_addr;
  logic [31:0] ldr_wdata;
  logic        ldr_gnt;

  logic        rsp_valid;
  logic        rsp_id;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ldr_req, ldr_we, ldr_lock, ldr_addr, ldr_wdata,
    input  mem_rdata,
    output cpu_gnt, cpu_stall, ldr_gnt,
    output rsp_valid, rsp_id, rsp_rdata, rsp_err,
    output mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ldr_req, ldr_we, ldr_lock, ldr_addr, ldr_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_stall, ldr_gnt,
    input  rsp_valid, rsp_id, rsp_rdata, rsp_err,
    input  mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dmem_age_counter.sv
// Saturating up-counter; sat flags that the count has reached MAX.
module dmem_age_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign sat = (cnt_q == W'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: cpu first, loader aged,
// optional loader burst lock, range check and one registered response per grant.
//
//   state  | meaning
//   ARB    | cpu has priority unless the loader has waited MAX_WAIT cycles
//   LOCKED | loader burst in progress; cpu is stalled
module dmem_arbiter #(
  parameter logic [31:0] MEM_BASE  = dmem_pkg::MEM_BASE,
  parameter int          MAX_WAIT  = 4,
  parameter int          BURST_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);

  import dmem_pkg::*;

  localparam bit LOCK_EN    = (BURST_MAX > 1);
  localparam int BURST_LAST = (BURST_MAX > 1) ? BURST_MAX - 1 : 1;

  state_e      state_q, state_d;
  logic        cpu_gnt, ldr_gnt, any_gnt;
  logic        wait_sat, burst_sat;
  logic        gnt_we, in_range;
  logic [31:0] gnt_addr, gnt_wdata;

  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  always_comb begin
    state_d = state_q;
    cpu_gnt = 1'b0;
    ldr_gnt = 1'b0;
    case (state_q)
      ARB: begin
        if (bus.cpu_req && bus.ldr_req) begin
          if (wait_sat) ldr_gnt = 1'b1;
          else          cpu_gnt = 1'b1;
        end else if (bus.cpu_req) begin
          cpu_gnt = 1'b1;
        end else if (bus.ldr_req) begin
          ldr_gnt = 1'b1;
        end
        if (ldr_gnt && bus.ldr_lock && LOCK_EN) state_d = LOCKED;
      end
      LOCKED: begin
        if (bus.ldr_req) begin
          ldr_gnt = 1'b1;
          // burst_sat means this grant is the BURST_MAX-th of the burst
          if (!bus.ldr_lock || burst_sat) state_d = ARB;
        end else begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    gnt_addr  = bus.cpu_addr;
    gnt_wdata = '0;
    gnt_we    = 1'b0;
    if (ldr_gnt) begin
      gnt_addr  = bus.ldr_addr;
      gnt_wdata = bus.ldr_wdata;
      gnt_we    = bus.ldr_we;
    end else if (cpu_gnt) begin
      gnt_addr  = bus.cpu_addr;
      gnt_wdata = bus.cpu_wdata;
      gnt_we    = bus.cpu_we;
    end
    any_gnt     = cpu_gnt | ldr_gnt;
    in_range    = (gnt_addr >= MEM_BASE);
    rsp_valid_d = any_gnt;
    rsp_id_d    = ldr_gnt ? ID_LDR : ID_CPU;
    rsp_err_d   = any_gnt & ~in_range;
    rsp_rdata_d = (any_gnt && !gnt_we && in_range) ? bus.mem_rdata : '0;
  end

  dmem_age_counter #(.MAX(MAX_WAIT)) u_wait (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bus.ldr_req & ~ldr_gnt),
    .clr   (ldr_gnt | ~bus.ldr_req),
    .sat   (wait_sat)
  );

  dmem_age_counter #(.MAX(BURST_LAST)) u_burst (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ldr_gnt),
    .clr   (state_d == ARB),
    .sat   (burst_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ARB;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= ID_CPU;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.ldr_gnt   = ldr_gnt;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_gnt;
  assign bus.mem_we    = gnt_we & in_range;
  assign bus.mem_addr  = gnt_addr;
  assign bus.mem_wdata = gnt_wdata;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 256-word behavioural memory.
module tb_dmem_arbiter;

  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] mem [0:255];

  dmem_arbiter_if bus();

  dmem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] preload(input int idx);
    return 32'hC0DE0000 | 32'(idx);
  endfunction

  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < 256; j++) mem[j] <= preload(j);
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 32'h0;
    bus.cpu_wdata = 32'h0;
    bus.ldr_req   = 1'b0;
    bus.ldr_we    = 1'b0;
    bus.ldr_lock  = 1'b0;
    bus.ldr_addr  = 32'h0;
    bus.ldr_wdata = 32'h0;
  endtask

  task automatic to_check();
    @(negedge clk);
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  i;
    bit  exp_l;
    rst_n = 1'b0;
    idle();
    to_drive();
    to_drive();
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_id",    32'(bus.rsp_id),    32'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata,      32'd0);
    chk("reset_rsp_err",   32'(bus.rsp_err),   32'd0);
    chk("reset_state",     32'(dut.state_q),   32'(ARB));
    chk("reset_wait_cnt",  32'(dut.u_wait.cnt_q), 32'd0);
    rst_n = 1'b1;

    // store then load the same word
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
    bus.cpu_addr = 32'hFFFFFF10; bus.cpu_wdata = 32'hDEADBEEF;
    to_check();
    chk("st_cpu_gnt",   32'(bus.cpu_gnt),   32'd1);
    chk("st_cpu_stall", 32'(bus.cpu_stall), 32'd0);
    chk("st_mem_we",    32'(bus.mem_we),    32'd1);
    chk("st_mem_addr",  bus.mem_addr,       32'hFFFFFF10);
    chk("st_mem_wdata", bus.mem_wdata,      32'hDEADBEEF);
    to_drive();
    bus.cpu_we = 1'b0; bus.cpu_wdata = 32'h0;
    to_check();
    chk("ld_cpu_gnt",     32'(bus.cpu_gnt),   32'd1);
    chk("ld_cpu_stall",   32'(bus.cpu_stall), 32'd0);
    chk("ld_mem_we",      32'(bus.mem_we),    32'd0);
    chk("st_rsp_valid",   32'(bus.rsp_valid), 32'd1);
    chk("st_rsp_rdata",   bus.rsp_rdata,      32'd0);
    to_drive();
    idle();
    to_check();
    chk("ld_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("ld_rsp_id",    32'(bus.rsp_id),    32'd0);
    chk("ld_rsp_rdata", bus.rsp_rdata,      32'hDEADBEEF);
    chk("ld_rsp_err",   32'(bus.rsp_err),   32'd0);
    to_drive();

    // continuous contention: four cpu grants, then one aged loader grant
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'hFFFFFF10;
    bus.ldr_req = 1'b1; bus.ldr_addr = 32'hFFFFFF20;
    for (int k = 0; k < 10; k++) begin
      to_check();
      chk($sformatf("age_ldr_gnt[%0d]", k),   32'(bus.ldr_gnt),   32'(k % 5 == 4));
      chk($sformatf("age_cpu_gnt[%0d]", k),   32'(bus.cpu_gnt),   32'(k % 5 != 4));
      chk($sformatf("age_cpu_stall[%0d]", k), 32'(bus.cpu_stall), 32'(k % 5 == 4));
      if (k > 0) chk($sformatf("age_rsp_id[%0d]", k), 32'(bus.rsp_id), 32'((k - 1) % 5 == 4));
      if (k == 5) chk("age_ldr_rdata", bus.rsp_rdata, preload(32'h20));
      to_drive();
    end
    idle();
    to_drive();

    // locked write burst of 10 with cpu requesting
    i = 0;
    bus.ldr_we = 1'b1;
    bus.cpu_addr = 32'hFFFFFF10;
    for (int c = 0; c < 15; c++) begin
      bus.cpu_req   = (c < 13);
      bus.ldr_req   = 1'b1;
      bus.ldr_lock  = (i != 9);
      bus.ldr_addr  = 32'hFFFFFF80 + 32'(i);
      bus.ldr_wdata = 32'h1000 + 32'(i);
      exp_l = (c >= 4 && c < 12) || c >= 13;
      to_check();
      chk($sformatf("burst_ldr_gnt[%0d]", c), 32'(bus.ldr_gnt), 32'(exp_l));
      chk($sformatf("burst_cpu_gnt[%0d]", c), 32'(bus.cpu_gnt), 32'(!exp_l && c < 13));
      if (c >= 4 && c < 12) chk($sformatf("burst_stall[%0d]", c), 32'(bus.cpu_stall), 32'd1);
      if (c == 11) chk("burst_state_locked", 32'(dut.state_q), 32'(LOCKED));
      if (c == 12) chk("burst_state_arb",    32'(dut.state_q), 32'(ARB));
      to_drive();
      if (exp_l) i++;
    end
    idle();
    to_check();
    chk("burst_end_state", 32'(dut.state_q), 32'(ARB));
    chk("burst_mem_87", mem[8'h87], 32'h1007);
    chk("burst_mem_88", mem[8'h88], 32'h1008);
    chk("burst_mem_89", mem[8'h89], 32'h1009);
    to_drive();

    // out-of-range accesses and window boundary
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
    bus.cpu_addr = 32'h00000040; bus.cpu_wdata = 32'hBAD0BAD0;
    to_check();
    chk("oor_st_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    chk("oor_st_mem_we",  32'(bus.mem_we),  32'd0);
    to_drive();
    idle();
    bus.ldr_req = 1'b1; bus.ldr_addr = 32'h00000040;
    to_check();
    chk("oor_ld_ldr_gnt", 32'(bus.ldr_gnt), 32'd1);
    chk("oor_st_valid",   32'(bus.rsp_valid), 32'd1);
    chk("oor_st_err",     32'(bus.rsp_err),   32'd1);
    chk("oor_st_rdata",   bus.rsp_rdata,      32'd0);
    chk("oor_st_id",      32'(bus.rsp_id),    32'd0);
    to_drive();
    idle();
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'hFFFFFF00;
    to_check();
    chk("oor_ld_id",    32'(bus.rsp_id),  32'd1);
    chk("oor_ld_err",   32'(bus.rsp_err), 32'd1);
    chk("oor_ld_rdata", bus.rsp_rdata,    32'd0);
    to_drive();
    bus.cpu_addr = 32'hFFFFFEFF;
    to_check();
    chk("base_err",   32'(bus.rsp_err), 32'd0);
    chk("base_rdata", bus.rsp_rdata,    preload(32'h00));
    to_drive();
    idle();
    to_check();
    chk("below_base_err",   32'(bus.rsp_err), 32'd1);
    chk("below_base_rdata", bus.rsp_rdata,    32'd0);
    chk("oor_mem_kept",     mem[8'h40],       preload(32'h40));
    to_drive();

    // reset during the third cycle of a locked burst
    bus.ldr_req = 1'b1; bus.ldr_lock = 1'b1; bus.ldr_we = 1'b1;
    bus.ldr_addr = 32'hFFFFFFA0; bus.ldr_wdata = 32'h5555AAAA;
    to_check();
    chk("rst_burst_gnt0", 32'(bus.ldr_gnt), 32'd1);
    to_drive();
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'hFFFFFF10;
    to_check();
    chk("rst_burst_gnt1",  32'(bus.ldr_gnt),   32'd1);
    chk("rst_burst_stall", 32'(bus.cpu_stall), 32'd1);
    chk("rst_burst_state", 32'(dut.state_q),   32'(LOCKED));
    to_drive();
    rst_n = 1'b0;
    to_drive();
    rst_n = 1'b1;
    to_check();
    chk("rst_rel_state",     32'(dut.state_q),       32'(ARB));
    chk("rst_rel_rsp_valid", 32'(bus.rsp_valid),     32'd0);
    chk("rst_rel_wait_cnt",  32'(dut.u_wait.cnt_q),  32'd0);
    chk("rst_rel_cpu_gnt",   32'(bus.cpu_gnt),       32'd1);
    chk("rst_rel_ldr_gnt",   32'(bus.ldr_gnt),       32'd0);
    to_drive();

    // quiet bus
    idle();
    bus.cpu_addr = 32'h00001234;
    to_drive();
    for (int k = 0; k < 5; k++) begin
      to_check();
      chk($sformatf("idle_cpu_gnt[%0d]", k),   32'(bus.cpu_gnt),   32'd0);
      chk($sformatf("idle_ldr_gnt[%0d]", k),   32'(bus.ldr_gnt),   32'd0);
      chk($sformatf("idle_cpu_stall[%0d]", k), 32'(bus.cpu_stall), 32'd0);
      chk($sformatf("idle_mem_we[%0d]", k),    32'(bus.mem_we),    32'd0);
      chk($sformatf("idle_rsp_valid[%0d]", k), 32'(bus.rsp_valid), 32'd0);
      chk($sformatf("idle_mem_addr[%0d]", k),  bus.mem_addr,       32'h00001234);
      chk($sformatf("idle_mem_wdata[%0d]", k), bus.mem_wdata,      32'd0);
      to_drive();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
